eth_rx_packer: RTL and testbench

- Receive-direction counterpart of the TX widening buffer.
- Accepts the MAC RX byte stream (AXI-Stream, 8-bit), packs bytes little-endian into 64-bit words and writes them into a slotted dual-port RX frame buffer through its write port.
- Commits each good frame as a slot with byte length for the 64-bit bus-side reader; drops errored, oversize and no-slot frames.
- Sits between the RX MAC and the RX buffer RAM, all in the clk_i domain.

---
 rtl/eth_rx_pkg.sv | 32 +++
 rtl/eth_rx_slot_ring.sv | 47 ++++
 rtl/eth_rx_packer.sv | 140 ++++++++++++++
 tb/tb_eth_rx_packer.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_pkg.sv
// eth_rx_pkg: shared defaults, width helpers and types for the RX byte-to-word packer.
package eth_rx_pkg;

    localparam int NUM_SLOTS_DEF  = 4;
    localparam int SLOT_WORDS_DEF = 256;
    localparam int STAT_SLOT_W    = 8;
    localparam int STAT_LEN_W     = 16;

    function automatic int addr_w(input int num_slots, input int slot_words);
        return $clog2(num_slots * slot_words);
    endfunction

    function automatic int len_w(input int slot_words);
        return $clog2(slot_words * 8 + 1);
    endfunction

    function automatic int idx_w(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

    function automatic int cnt_w(input int num_slots);
        return $clog2(num_slots + 1);
    endfunction

    typedef enum logic [1:0] {IDLE, FILL, DROP} rx_state_e;

    typedef struct packed {
        logic [STAT_SLOT_W-1:0] slot;
        logic [STAT_LEN_W-1:0]  len;
    } rx_status_t;

endpackage

// File: rtl/eth_rx_slot_ring.sv
// eth_rx_slot_ring: write/read slot pointers and pending count of committed frames.
module eth_rx_slot_ring
    import eth_rx_pkg::*;
#(
    parameter int NUM_SLOTS = NUM_SLOTS_DEF,
    localparam int SLOT_W   = idx_w(NUM_SLOTS),
    localparam int PEND_W   = cnt_w(NUM_SLOTS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              commit_i,
    input  logic              release_i,
    output logic [SLOT_W-1:0] wr_slot_o,
    output logic [PEND_W-1:0] pending_o,
    output logic              full_o
);

    logic [SLOT_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              rel;

    // A release with nothing pending is ignored; commit plus release nets to zero.
    assign rel = release_i & (pend_q != '0);

    always_comb begin
        wr_d   = commit_i ? wr_q + SLOT_W'(1) : wr_q;
        rd_d   = rel ? rd_q + SLOT_W'(1) : rd_q;
        pend_d = pend_q + PEND_W'(commit_i) - PEND_W'(rel);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q   <= '0;
            rd_q   <= '0;
            pend_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            pend_q <= pend_d;
        end
    end

    assign wr_slot_o = wr_q;
    assign pending_o = pend_q;
    assign full_o    = pend_q == PEND_W'(NUM_SLOTS);

endmodule

// File: rtl/eth_rx_packer.sv
// eth_rx_packer: packs the MAC RX byte stream little-endian into 64-bit words of a slotted
// frame buffer, committing good frames and dropping errored, oversize and no-slot frames.
module eth_rx_packer
    import eth_rx_pkg::*;
#(
    parameter int NUM_SLOTS  = NUM_SLOTS_DEF,
    parameter int SLOT_WORDS = SLOT_WORDS_DEF,
    parameter int ADDR_W     = addr_w(NUM_SLOTS, SLOT_WORDS),
    parameter int LEN_W      = len_w(SLOT_WORDS),
    localparam int SLOT_W    = idx_w(NUM_SLOTS),
    localparam int PEND_W    = cnt_w(NUM_SLOTS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        s_tdata_i,
    input  logic              s_tvalid_i,
    input  logic              s_tlast_i,
    input  logic              s_tuser_i,
    output logic              s_tready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [63:0]       mem_wdata_o,
    output logic [7:0]        mem_be_o,
    output logic              rx_done_o,
    output logic [SLOT_W-1:0] rx_slot_o,
    output logic [LEN_W-1:0]  rx_len_o,
    input  logic              slot_release_i,
    output logic [PEND_W-1:0] rx_pending_o,
    output logic [15:0]       drop_cnt_o
);

    rx_state_e         state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [63:0]       asm_q, asm_d, asm_n, wdata_q, wdata_d;
    logic [7:0]        abe_q, abe_d, abe_n, be_q, be_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d, done_q, done_d, rdy_q;
    rx_status_t        stat_q, stat_d;
    logic [15:0]       drop_q, drop_d;
    logic              accept, fill, full, commit, drop_inc, oversize;
    logic [SLOT_W-1:0] wr_slot;
    logic [2:0]        lane;

    assign accept   = s_tvalid_i & rdy_q;
    assign lane     = cnt_q[2:0];
    assign oversize = cnt_q == LEN_W'(SLOT_WORDS * 8);
    // Bytes that land in the buffer; every other accepted byte is discarded.
    assign fill     = accept & (((state_q == IDLE) & ~full) | ((state_q == FILL) & ~oversize));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        abe_d    = abe_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        we_d     = 1'b0;
        done_d   = 1'b0;
        stat_d   = stat_q;
        commit   = 1'b0;
        drop_inc = 1'b0;
        asm_n    = asm_q;
        asm_n[{lane, 3'b000} +: 8] = s_tdata_i;
        abe_n    = abe_q | (8'd1 << lane);
        if (fill) begin
            we_d     = (lane == 3'd7) | s_tlast_i;
            state_d  = s_tlast_i ? IDLE : FILL;
            cnt_d    = s_tlast_i ? '0 : cnt_q + LEN_W'(1);
            asm_d    = we_d ? '0 : asm_n;
            abe_d    = we_d ? '0 : abe_n;
            addr_d   = we_d ? ADDR_W'(wr_slot) * ADDR_W'(SLOT_WORDS) + ADDR_W'(cnt_q >> 3) : addr_q;
            wdata_d  = we_d ? asm_n : wdata_q;
            be_d     = we_d ? abe_n : be_q;
            commit   = s_tlast_i & ~s_tuser_i;
            drop_inc = s_tlast_i & s_tuser_i;
            done_d   = commit;
            stat_d.slot = commit ? STAT_SLOT_W'(wr_slot) : stat_q.slot;
            stat_d.len  = commit ? STAT_LEN_W'(cnt_q + LEN_W'(1)) : stat_q.len;
        end else if (accept) begin
            state_d  = s_tlast_i ? IDLE : DROP;
            cnt_d    = '0;
            asm_d    = '0;
            abe_d    = '0;
            drop_inc = s_tlast_i;
        end
        drop_d = (drop_inc && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
            abe_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            stat_q  <= '0;
            drop_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            abe_q   <= abe_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            done_q  <= done_d;
            stat_q  <= stat_d;
            drop_q  <= drop_d;
            rdy_q   <= 1'b1;
        end
    end

    eth_rx_slot_ring #(.NUM_SLOTS(NUM_SLOTS)) u_ring (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .commit_i  (commit),
        .release_i (slot_release_i),
        .wr_slot_o (wr_slot),
        .pending_o (rx_pending_o),
        .full_o    (full)
    );

    assign s_tready_o  = rdy_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_be_o    = be_q;
    assign rx_done_o   = done_q;
    assign rx_slot_o   = SLOT_W'(stat_q.slot);
    assign rx_len_o    = LEN_W'(stat_q.len);
    assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_eth_rx_packer.sv
// tb_eth_rx_packer: randomized frames checked against a frame-level model of slots,
// packed words, commits and drop counts.
module tb_eth_rx_packer;

    localparam int NS = 4;
    localparam int SW = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_tdata = '0;
    logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0, slot_release = 1'b0;
    logic        s_tready_o, mem_we_o, rx_done_o;
    logic [9:0]  mem_addr_o;
    logic [63:0] mem_wdata_o;
    logic [7:0]  mem_be_o;
    logic [1:0]  rx_slot_o;
    logic [11:0] rx_len_o;
    logic [2:0]  rx_pending_o;
    logic [15:0] drop_cnt_o;

    eth_rx_packer dut (
        .clk_i(clk), .rst_ni(rst_n), .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid),
        .s_tlast_i(s_tlast), .s_tuser_i(s_tuser), .s_tready_o(s_tready_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_be_o(mem_be_o), .rx_done_o(rx_done_o), .rx_slot_o(rx_slot_o),
        .rx_len_o(rx_len_o), .slot_release_i(slot_release), .rx_pending_o(rx_pending_o),
        .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int m_wr = 0, m_pend = 0, m_drop = 0;
    bit gaps_en = 1'b1;
    logic [81:0] act_w[$], exp_w[$];
    logic [14:0] act_d[$], exp_d[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we_o) act_w.push_back({mem_addr_o, mem_wdata_o, mem_be_o});
            if (rx_done_o) act_d.push_back({mem_we_o, rx_slot_o, rx_len_o});
        end
    end

    task automatic drive_byte(input logic [7:0] d, input logic last, input logic user, input logic rel);
        if (gaps_en && $urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
            s_tvalid = 1'b0; s_tdata = 8'($urandom); s_tlast = 1'($urandom);
            s_tuser = 1'($urandom); slot_release = 1'b0;
        end
        @(posedge clk); #1;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = last; s_tuser = user; slot_release = rel;
    endtask

    task automatic settle();
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0; slot_release = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic release_pulse();
        @(posedge clk); #1;
        slot_release = 1'b1;
        @(posedge clk); #1;
        slot_release = 1'b0;
        if (m_pend > 0) m_pend--;
    endtask

    // Builds the frame, predicts its buffer words and outcome, then streams it.
    task automatic send_frame(input int len, input bit err, input bit rel_last, input bit ramp);
        logic [7:0] bytes[$];
        logic [63:0] data;
        logic [7:0] be;
        int nb;
        bit rel_ok;
        for (int i = 0; i < len; i++) bytes.push_back(ramp ? 8'(i + 1) : 8'($urandom));
        rel_ok = rel_last && m_pend > 0;
        if (m_pend == NS) begin
            if (m_drop < 65535) m_drop++;
        end else begin
            nb = (len > SW * 8) ? SW * 8 : len;
            for (int w = 0; w < (nb + 7) / 8; w++) begin
                data = '0;
                be = '0;
                for (int b = 0; b < 8 && w * 8 + b < nb; b++) begin
                    data[8*b +: 8] = bytes[w*8+b];
                    be[b] = 1'b1;
                end
                exp_w.push_back({10'(m_wr * SW + w), data, be});
            end
            if (len > SW * 8 || err) begin
                if (m_drop < 65535) m_drop++;
            end else begin
                exp_d.push_back({1'b1, 2'(m_wr), 12'(len)});
                m_wr = (m_wr + 1) % NS;
                m_pend++;
            end
        end
        if (rel_ok) m_pend--;
        for (int i = 0; i < len; i++)
            drive_byte(bytes[i], i == len - 1, (i == len - 1) ? err : 1'($urandom), (i == len - 1) && rel_last);
        settle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        tests++;
        if ({s_tready_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, rx_done_o, rx_slot_o, rx_len_o, rx_pending_o, drop_cnt_o} !== '0) begin
            fails++;
            $display("FAIL reset outputs: got tready=%b we=%b addr=%h pend=%0d drop=%0d, want all 0", s_tready_o, mem_we_o, mem_addr_o, rx_pending_o, drop_cnt_o);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (s_tready_o !== 1'b1) begin
            fails++;
            $display("FAIL reset tready: got %b want 1", s_tready_o);
        end
    endtask

    task automatic test_eight();
        send_frame(8, 1'b0, 1'b0, 1'b1);
        tests++;
        if (act_w.size() != 1 || act_d.size() != 1) begin
            fails++;
            $display("FAIL eight counts: writes %0d dones %0d, want 1 1", act_w.size(), act_d.size());
        end else begin
            tests++;
            if (act_w[0] !== {10'd0, 64'h0807060504030201, 8'hFF}) begin
                fails++;
                $display("FAIL eight write: got %h want %h", act_w[0], {10'd0, 64'h0807060504030201, 8'hFF});
            end
            tests++;
            if (act_d[0] !== {1'b1, 2'd0, 12'd8}) begin
                fails++;
                $display("FAIL eight done: got %h want %h", act_d[0], {1'b1, 2'd0, 12'd8});
            end
        end
        act_w.delete(); exp_w.delete(); act_d.delete(); exp_d.delete();
    endtask

    task automatic test_thirteen();
        send_frame(13, 1'b0, 1'b0, 1'b0);
        tests++;
        if (act_w.size() != exp_w.size()) begin
            fails++;
            $display("FAIL thirteen writes: got %0d want %0d", act_w.size(), exp_w.size());
        end else foreach (exp_w[i]) begin
            tests++;
            if (act_w[i] !== exp_w[i]) begin
                fails++;
                $display("FAIL thirteen write[%0d]: got %h want %h", i, act_w[i], exp_w[i]);
            end
        end
        tests++;
        if (act_d.size() != 1 || act_d[0] !== exp_d[0]) begin
            fails++;
            $display("FAIL thirteen done: got %0d entries first %h want %h", act_d.size(), act_d.size() ? act_d[0] : 15'h0, exp_d[0]);
        end
        tests++;
        if (rx_pending_o !== 3'(m_pend)) begin
            fails++;
            $display("FAIL thirteen pending: got %0d want %0d", rx_pending_o, m_pend);
        end
        act_w.delete(); exp_w.delete(); act_d.delete(); exp_d.delete();
    endtask

    task automatic test_error();
        int err_slot;
        err_slot = m_wr;
        send_frame(10, 1'b1, 1'b0, 1'b0);
        tests++;
        if (act_w.size() != exp_w.size()) begin
            fails++;
            $display("FAIL error writes: got %0d want %0d", act_w.size(), exp_w.size());
        end else foreach (exp_w[i]) begin
            tests++;
            if (act_w[i] !== exp_w[i]) begin
                fails++;
                $display("FAIL error write[%0d]: got %h want %h", i, act_w[i], exp_w[i]);
            end
        end
        tests++;
        if (act_d.size() != 0) begin
            fails++;
            $display("FAIL error done: got %0d commits want 0", act_d.size());
        end
        tests++;
        if (drop_cnt_o !== 16'(m_drop)) begin
            fails++;
            $display("FAIL error drop_cnt: got %0d want %0d", drop_cnt_o, m_drop);
        end
        act_w.delete(); exp_w.delete(); act_d.delete(); exp_d.delete();
        send_frame(5, 1'b0, 1'b0, 1'b0);
        tests++;
        if (act_d.size() != 1 || act_d[0][13:12] !== 2'(err_slot)) begin
            fails++;
            $display("FAIL error reuse slot: got %0d commits slot %0d want slot %0d", act_d.size(), act_d.size() ? act_d[0][13:12] : 2'd0, err_slot);
        end
        act_w.delete(); exp_w.delete(); act_d.delete(); exp_d.delete();
    endtask

    task automatic test_full();
        repeat (NS) release_pulse();
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (rx_pending_o !== 3'(m_pend)) begin
            fails++;
            $display("FAIL full drain pending: got %0d want %0d", rx_pending_o, m_pend);
        end
        repeat (NS) send_frame($urandom_range(1, 40), 1'b0, 1'b0, 1'b0);
        tests++;
        if (rx_pending_o !== 3'(NS)) begin
            fails++;
            $display("FAIL full pending: got %0d want %0d", rx_pending_o, NS);
        end
        act_w.delete(); exp_w.delete(); act_d.delete(); exp_d.delete();
        send_frame(20, 1'b0, 1'b0, 1'b0);
        tests++;
        if (act_w.size() != 0 || act_d.size() != 0) begin
            fails++;
            $display("FAIL full no-slot: got %0d writes %0d commits want 0 0", act_w.size(), act_d.size());
        end
        tests++;
        if (drop_cnt_o !== 16'(m_drop)) begin
            fails++;
            $display("FAIL full drop_cnt: got %0d want %0d", drop_cnt_o, m_drop);
        end
        release_pulse();
        send_frame(16, 1'b0, 1'b0, 1'b0);
        tests++;
        if (act_d.size() != 1 || act_d[0] !== exp_d[0]) begin
            fails++;
            $display("FAIL full sixth done: got %0d entries want %h", act_d.size(), exp_d[0]);
        end
        tests++;
        if (rx_pending_o !== 3'(NS)) begin
            fails++;
            $display("FAIL full sixth pending: got %0d want %0d", rx_pending_o, NS);
        end
        act_w.delete(); exp_w.delete(); act_d.delete(); exp_d.delete();
    endtask

    task automatic test_oversize();
        repeat (NS) release_pulse();
        gaps_en = 1'b0;
        send_frame(SW * 8 + 1, 1'b0, 1'b0, 1'b0);
        gaps_en = 1'b1;
        tests++;
        if (act_w.size() != SW) begin
            fails++;
            $display("FAIL oversize writes: got %0d want %0d", act_w.size(), SW);
        end else foreach (exp_w[i]) begin
            tests++;
            if (act_w[i] !== exp_w[i]) begin
                fails++;
                $display("FAIL oversize write[%0d]: got %h want %h", i, act_w[i], exp_w[i]);
            end
        end
        tests++;
        if (act_d.size() != 0 || drop_cnt_o !== 16'(m_drop)) begin
            fails++;
            $display("FAIL oversize drop: commits %0d drop_cnt %0d want 0 %0d", act_d.size(), drop_cnt_o, m_drop);
        end
        act_w.delete(); exp_w.delete(); act_d.delete(); exp_d.delete();
        send_frame(9, 1'b0, 1'b0, 1'b0);
        send_frame(12, 1'b0, 1'b1, 1'b0);
        tests++;
        if (act_d.size() != 2 || rx_pending_o !== 3'(m_pend) || m_pend != 1) begin
            fails++;
            $display("FAIL commit+release: commits %0d pending %0d want 2 1", act_d.size(), rx_pending_o);
        end
        act_w.delete(); exp_w.delete(); act_d.delete(); exp_d.delete();
    endtask

    task automatic test_random();
        for (int f = 0; f < 14; f++) begin
            if ($urandom_range(0, 2) == 0) release_pulse();
            send_frame($urandom_range(1, 48), $urandom_range(0, 4) == 0, 1'($urandom), 1'b0);
            tests++;
            if (act_w.size() != exp_w.size() || act_d.size() != exp_d.size()) begin
                fails++;
                $display("FAIL random[%0d] counts: writes %0d/%0d commits %0d/%0d", f, act_w.size(), exp_w.size(), act_d.size(), exp_d.size());
            end else begin
                foreach (exp_w[i]) begin
                    tests++;
                    if (act_w[i] !== exp_w[i]) begin
                        fails++;
                        $display("FAIL random[%0d] write[%0d]: got %h want %h", f, i, act_w[i], exp_w[i]);
                    end
                end
                foreach (exp_d[i]) begin
                    tests++;
                    if (act_d[i] !== exp_d[i]) begin
                        fails++;
                        $display("FAIL random[%0d] done: got %h want %h", f, act_d[i], exp_d[i]);
                    end
                end
            end
            tests++;
            if (rx_pending_o !== 3'(m_pend) || drop_cnt_o !== 16'(m_drop)) begin
                fails++;
                $display("FAIL random[%0d] status: pending %0d drop %0d want %0d %0d", f, rx_pending_o, drop_cnt_o, m_pend, m_drop);
            end
            act_w.delete(); exp_w.delete(); act_d.delete(); exp_d.delete();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) drive_byte(8'($urandom), 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        s_tvalid = 1'b0;
        #1;
        tests++;
        if ({s_tready_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, rx_done_o, rx_slot_o, rx_len_o, rx_pending_o, drop_cnt_o} !== '0) begin
            fails++;
            $display("FAIL mid-frame reset outputs: tready=%b we=%b addr=%h pend=%0d drop=%0d want all 0", s_tready_o, mem_we_o, mem_addr_o, rx_pending_o, drop_cnt_o);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        m_wr = 0; m_pend = 0; m_drop = 0;
        act_w.delete(); exp_w.delete(); act_d.delete(); exp_d.delete();
        repeat (2) @(posedge clk);
        send_frame(8, 1'b0, 1'b0, 1'b0);
        tests++;
        if (act_w.size() != 1 || act_w[0] !== exp_w[0] || act_w[0][81:72] !== 10'd0) begin
            fails++;
            $display("FAIL post-reset write: got %0d writes first %h want %h", act_w.size(), act_w.size() ? act_w[0] : 82'h0, exp_w[0]);
        end
        tests++;
        if (act_d.size() != 1 || act_d[0] !== {1'b1, 2'd0, 12'd8}) begin
            fails++;
            $display("FAIL post-reset done: got %0d commits first %h want %h", act_d.size(), act_d.size() ? act_d[0] : 15'h0, {1'b1, 2'd0, 12'd8});
        end
        tests++;
        if (drop_cnt_o !== 16'd0) begin
            fails++;
            $display("FAIL post-reset drop_cnt: got %0d want 0", drop_cnt_o);
        end
    endtask

    initial begin
        test_reset();
        test_eight();
        test_thirteen();
        test_error();
        test_full();
        test_oversize();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
